// File: rtl/rs_age.sv
// rs_age: reservation station with CDB wake-up, insert-time bypass and oldest-ready issue.
// Age is a pairwise "dispatched-before" matrix, so no sequence counter exists that could wrap.
module rs_age #(
  parameter int DEPTH = 8,
  parameter int TAG_W = 4,
  parameter int NCDB  = 2,
  parameter int OP_W  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rdy,
  input  logic                     flush,
  input  logic                     in_vld,
  input  logic [31:0]              in_vj,
  input  logic [TAG_W-1:0]         in_qj,
  input  logic [31:0]              in_vk,
  input  logic [TAG_W-1:0]         in_qk,
  input  logic [OP_W-1:0]          in_op,
  input  logic [TAG_W-1:0]         in_dest,
  input  logic [31:0]              in_pc,
  input  logic [31:0]              in_imm,
  input  logic [NCDB-1:0]          cdb_vld,
  input  logic [NCDB*TAG_W-1:0]    cdb_tag,
  input  logic [NCDB*32-1:0]       cdb_val,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     iss_vld,
  input  logic                     iss_rdy,
  output logic [31:0]              iss_vj,
  output logic [31:0]              iss_vk,
  output logic [31:0]              iss_imm,
  output logic [31:0]              iss_pc,
  output logic [OP_W-1:0]          iss_op,
  output logic [TAG_W-1:0]         iss_dest
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = IDX_W + 1;

  logic [DEPTH-1:0] busy;
  logic [DEPTH-1:0] older [DEPTH];
  logic [31:0]      vj    [DEPTH];
  logic [31:0]      vk    [DEPTH];
  logic [31:0]      pc    [DEPTH];
  logic [31:0]      imm   [DEPTH];
  logic [TAG_W-1:0] qj    [DEPTH];
  logic [TAG_W-1:0] qk    [DEPTH];
  logic [TAG_W-1:0] dest  [DEPTH];
  logic [OP_W-1:0]  op    [DEPTH];

  logic [DEPTH-1:0] ready;
  logic [DEPTH-1:0] wj_hit;
  logic [DEPTH-1:0] wk_hit;
  logic [31:0]      wj_val [DEPTH];
  logic [31:0]      wk_val [DEPTH];
  logic [IDX_W-1:0] free_idx;
  logic [IDX_W-1:0] sel_idx;
  logic [32:0]      byp_j;
  logic [32:0]      byp_k;
  logic             accept;
  logic             load;

  // Returns {hit, value}; descending scan so the lowest matching port wins. Tag 0 never matches.
  function automatic logic [32:0] cdb_lookup(input logic [TAG_W-1:0]      tag,
                                             input logic [NCDB-1:0]       vld,
                                             input logic [NCDB*TAG_W-1:0] tags,
                                             input logic [NCDB*32-1:0]    vals);
    logic [32:0] r;
    r = '0;
    for (int k = NCDB - 1; k >= 0; k--) begin
      if (vld[k] && (tags[k*TAG_W +: TAG_W] != '0) && (tags[k*TAG_W +: TAG_W] == tag))
        r = {1'b1, vals[k*32 +: 32]};
    end
    return r;
  endfunction

  assign full   = (count == CNT_W'(DEPTH));
  assign accept = rdy && !flush && in_vld && !full;
  assign load   = rdy && !flush && (|ready) && (!iss_vld || iss_rdy);

  always_comb begin
    free_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!busy[i]) free_idx = IDX_W'(i);
    end
  end

  // An entry is oldest-ready when no other ready entry was dispatched before it.
  always_comb begin
    logic is_old;
    sel_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      ready[i] = busy[i] && (qj[i] == '0) && (qk[i] == '0);
    end
    for (int i = 0; i < DEPTH; i++) begin
      is_old = ready[i];
      for (int j = 0; j < DEPTH; j++) begin
        if (ready[j] && older[j][i]) is_old = 1'b0;
      end
      if (is_old) sel_idx = IDX_W'(i);
    end
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      {wj_hit[i], wj_val[i]} = cdb_lookup(qj[i], cdb_vld, cdb_tag, cdb_val);
      {wk_hit[i], wk_val[i]} = cdb_lookup(qk[i], cdb_vld, cdb_tag, cdb_val);
    end
    byp_j = cdb_lookup(in_qj, cdb_vld, cdb_tag, cdb_val);
    byp_k = cdb_lookup(in_qk, cdb_vld, cdb_tag, cdb_val);
  end

  // Control state: occupancy, age matrix and the issue output register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      busy     <= '0;
      count    <= '0;
      iss_vld  <= 1'b0;
      iss_vj   <= '0;
      iss_vk   <= '0;
      iss_imm  <= '0;
      iss_pc   <= '0;
      iss_op   <= '0;
      iss_dest <= '0;
      for (int i = 0; i < DEPTH; i++) older[i] <= '0;
    end else if (rdy) begin
      if (flush) begin
        busy    <= '0;
        count   <= '0;
        iss_vld <= 1'b0;
        for (int i = 0; i < DEPTH; i++) older[i] <= '0;
      end else begin
        if (accept) begin
          busy[free_idx]  <= 1'b1;
          older[free_idx] <= '0;
          for (int j = 0; j < DEPTH; j++) begin
            if (j != int'(free_idx)) older[j][free_idx] <= 1'b1;
          end
        end
        if (load) begin
          busy[sel_idx] <= 1'b0;
          iss_vld       <= 1'b1;
          iss_vj        <= vj[sel_idx];
          iss_vk        <= vk[sel_idx];
          iss_imm       <= imm[sel_idx];
          iss_pc        <= pc[sel_idx];
          iss_op        <= op[sel_idx];
          iss_dest      <= dest[sel_idx];
        end else if (iss_rdy) begin
          iss_vld <= 1'b0;
        end
        count <= count + CNT_W'(accept) - CNT_W'(load);
      end
    end
  end

  // Entry payload: wake-up of waiting operands, then insertion into the free slot.
  always_ff @(posedge clk) begin
    if (rst && rdy && !flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (busy[i] && wj_hit[i]) begin
          qj[i] <= '0;
          vj[i] <= wj_val[i];
        end
        if (busy[i] && wk_hit[i]) begin
          qk[i] <= '0;
          vk[i] <= wk_val[i];
        end
      end
      if (accept) begin
        qj[free_idx]   <= byp_j[32] ? '0 : in_qj;
        vj[free_idx]   <= byp_j[32] ? byp_j[31:0] : in_vj;
        qk[free_idx]   <= byp_k[32] ? '0 : in_qk;
        vk[free_idx]   <= byp_k[32] ? byp_k[31:0] : in_vk;
        op[free_idx]   <= in_op;
        dest[free_idx] <= in_dest;
        pc[free_idx]   <= in_pc;
        imm[free_idx]  <= in_imm;
      end
    end
  end

endmodule

// File: tb/tb_rs_age.sv
// tb_rs_age: scenario tasks for rs_age with an issue-order scoreboard checked on each handshake.
module tb_rs_age;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rdy = 1'b1;
  logic        flush = 1'b0;
  logic        in_vld = 1'b0;
  logic [31:0] in_vj = '0;
  logic [3:0]  in_qj = '0;
  logic [31:0] in_vk = '0;
  logic [3:0]  in_qk = '0;
  logic [3:0]  in_op = '0;
  logic [3:0]  in_dest = '0;
  logic [31:0] in_pc = '0;
  logic [31:0] in_imm = '0;
  logic [1:0]  cdb_vld = '0;
  logic [7:0]  cdb_tag = '0;
  logic [63:0] cdb_val = '0;
  logic        full;
  logic [3:0]  count;
  logic        iss_vld;
  logic        iss_rdy = 1'b1;
  logic [31:0] iss_vj, iss_vk, iss_imm, iss_pc;
  logic [3:0]  iss_op, iss_dest;

  typedef struct packed {
    logic [3:0]  op;
    logic [3:0]  dest;
    logic [31:0] vj;
    logic [31:0] vk;
    logic [31:0] imm;
    logic [31:0] pc;
  } exp_t;

  exp_t exp_q[$];
  int   tests_run = 0;
  int   tests_failed = 0;
  bit   mon_en = 1'b1;

  rs_age dut (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
    .in_vld(in_vld), .in_vj(in_vj), .in_qj(in_qj), .in_vk(in_vk), .in_qk(in_qk),
    .in_op(in_op), .in_dest(in_dest), .in_pc(in_pc), .in_imm(in_imm),
    .cdb_vld(cdb_vld), .cdb_tag(cdb_tag), .cdb_val(cdb_val),
    .full(full), .count(count), .iss_vld(iss_vld), .iss_rdy(iss_rdy),
    .iss_vj(iss_vj), .iss_vk(iss_vk), .iss_imm(iss_imm), .iss_pc(iss_pc),
    .iss_op(iss_op), .iss_dest(iss_dest)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic exp_t mk(input logic [3:0] d, input logic [31:0] vj_e, input logic [31:0] vk_e);
    exp_t e;
    e.op   = d + 4'd3;
    e.dest = d;
    e.vj   = vj_e;
    e.vk   = vk_e;
    e.imm  = 32'hA000 + 32'(d);
    e.pc   = 32'h1000 + 32'(d);
    return e;
  endfunction

  task automatic disp(input logic [3:0] d, input logic [3:0] qj_t, input logic [3:0] qk_t,
                      input logic [31:0] vj_v, input logic [31:0] vk_v);
    in_vld  = 1'b1;
    in_dest = d;
    in_qj   = qj_t;
    in_qk   = qk_t;
    in_vj   = vj_v;
    in_vk   = vk_v;
    in_op   = d + 4'd3;
    in_imm  = 32'hA000 + 32'(d);
    in_pc   = 32'h1000 + 32'(d);
  endtask

  // One clock; an issue handshake seen at the falling edge is checked against the scoreboard.
  task automatic tick();
    exp_t got, want;
    @(negedge clk);
    if (mon_en && rst && rdy && !flush && iss_vld && iss_rdy) begin
      got = '{op: iss_op, dest: iss_dest, vj: iss_vj, vk: iss_vk, imm: iss_imm, pc: iss_pc};
      tests_run++;
      if (exp_q.size() == 0) begin
        tests_failed++;
        $display("FAIL issue_unexpected: got dest %0d vj %h, required no issue", iss_dest, iss_vj);
      end else begin
        want = exp_q.pop_front();
        if (got !== want) begin
          tests_failed++;
          $display("FAIL issue_order: got dest %0d vj %h vk %h, required dest %0d vj %h vk %h",
                   got.dest, got.vj, got.vk, want.dest, want.vj, want.vk);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n = 0;
    iss_rdy = 1'b1;
    in_vld  = 1'b0;
    cdb_vld = '0;
    while ((iss_vld || count != 0) && n < 200) begin
      tick();
      n++;
    end
    tests_run++;
    if (iss_vld || count != 0 || exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL drain: got count %0d iss_vld %0b pending %0d, required 0 0 0",
               count, iss_vld, exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    tick();
    tick();
    tests_run++;
    if (iss_vld !== 1'b0) begin tests_failed++; $display("FAIL reset_iss_vld: got %0b, required 0", iss_vld); end
    tests_run++;
    if (count !== 4'd0) begin tests_failed++; $display("FAIL reset_count: got %0d, required 0", count); end
    tests_run++;
    if (full !== 1'b0) begin tests_failed++; $display("FAIL reset_full: got %0b, required 0", full); end
    tests_run++;
    if ({iss_vj, iss_vk, iss_imm, iss_pc, iss_op, iss_dest} !== '0) begin
      tests_failed++; $display("FAIL reset_iss_data: got vj %h dest %0d, required 0", iss_vj, iss_dest);
    end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_back_to_back();
    iss_rdy = 1'b1;
    for (int i = 0; i < 10; i++) begin
      disp(4'(i + 1), 4'd0, 4'd0, 32'h0B00 + 32'(i), 32'h0C00 + 32'(i));
      exp_q.push_back(mk(4'(i + 1), 32'h0B00 + 32'(i), 32'h0C00 + 32'(i)));
      tick();
      tests_run++;
      if (count !== 4'd1 || iss_vld !== (i != 0)) begin
        tests_failed++;
        $display("FAIL b2b_latency[%0d]: got count %0d iss_vld %0b, required 1 %0b", i, count, iss_vld, i != 0);
      end
    end
    drain();
  endtask

  task automatic test_wakeup_order();
    iss_rdy = 1'b1;
    disp(4'd1, 4'd3, 4'd0, 32'h1111_0000, 32'h0000_00A1);
    tick();
    disp(4'd2, 4'd0, 4'd0, 32'h0000_2222, 32'h0000_00B2);
    exp_q.push_back(mk(4'd2, 32'h0000_2222, 32'h0000_00B2));
    exp_q.push_back(mk(4'd1, 32'h3333_0003, 32'h0000_00A1));
    tick();
    in_vld = 1'b0;
    tests_run++;
    if (iss_vld !== 1'b0) begin tests_failed++; $display("FAIL wake_pre: got iss_vld %0b, required 0", iss_vld); end
    cdb_vld = 2'b01;
    cdb_tag = {4'd0, 4'd3};
    cdb_val = {32'h0, 32'h3333_0003};
    tick();
    cdb_vld = '0;
    tests_run++;
    if (iss_vld !== 1'b1 || iss_dest !== 4'd2 || count !== 4'd1) begin
      tests_failed++;
      $display("FAIL wake_b_first: got vld %0b dest %0d count %0d, required 1 2 1", iss_vld, iss_dest, count);
    end
    tick();
    tests_run++;
    if (iss_vld !== 1'b1 || iss_dest !== 4'd1 || iss_vj !== 32'h3333_0003) begin
      tests_failed++;
      $display("FAIL wake_a_next: got vld %0b dest %0d vj %h, required 1 1 33330003", iss_vld, iss_dest, iss_vj);
    end
    drain();
  endtask

  task automatic test_hold_age();
    exp_t want;
    exp_t got;
    iss_rdy = 1'b0;
    disp(4'd1, 4'd0, 4'd0, 32'hE0, 32'hF0);
    exp_q.push_back(mk(4'd1, 32'hE0, 32'hF0));
    tick();
    disp(4'd2, 4'd0, 4'd0, 32'hE1, 32'hF1);
    exp_q.push_back(mk(4'd2, 32'hE1, 32'hF1));
    tick();
    disp(4'd3, 4'd0, 4'd0, 32'hE2, 32'hF2);
    exp_q.push_back(mk(4'd3, 32'hE2, 32'hF2));
    tick();
    in_vld = 1'b0;
    // A valid broadcast with tag 0 must not disturb the ready entries that are waiting.
    cdb_vld = 2'b01;
    cdb_tag = '0;
    cdb_val = {32'h0, 32'hDEAD_BEEF};
    want = mk(4'd1, 32'hE0, 32'hF0);
    for (int k = 0; k < 5; k++) begin
      tick();
      got = '{op: iss_op, dest: iss_dest, vj: iss_vj, vk: iss_vk, imm: iss_imm, pc: iss_pc};
      tests_run++;
      if (iss_vld !== 1'b1 || got !== want || count !== 4'd2) begin
        tests_failed++;
        $display("FAIL hold[%0d]: got vld %0b dest %0d count %0d, required 1 1 2", k, iss_vld, iss_dest, count);
      end
    end
    cdb_vld = '0;
    iss_rdy = 1'b1;
    tick();
    tests_run++;
    if (iss_dest !== 4'd2 || iss_vj !== 32'hE1) begin
      tests_failed++;
      $display("FAIL age_oldest: got dest %0d vj %h, required 2 000000e1", iss_dest, iss_vj);
    end
    drain();
  endtask

  task automatic test_bypass();
    iss_rdy = 1'b1;
    disp(4'd6, 4'd0, 4'd7, 32'h6060, 32'hDEAD);
    cdb_vld = 2'b11;
    cdb_tag = {4'd7, 4'd7};
    cdb_val = {32'h9999, 32'h1234};
    exp_q.push_back(mk(4'd6, 32'h6060, 32'h1234));
    tick();
    in_vld  = 1'b0;
    cdb_vld = '0;
    tests_run++;
    if (iss_vld !== 1'b0 || count !== 4'd1) begin
      tests_failed++; $display("FAIL bypass_insert: got vld %0b count %0d, required 0 1", iss_vld, count);
    end
    tick();
    tests_run++;
    if (iss_vld !== 1'b1 || iss_vk !== 32'h1234) begin
      tests_failed++; $display("FAIL bypass_vk: got vld %0b vk %h, required 1 00001234", iss_vld, iss_vk);
    end
    disp(4'd9, 4'd2, 4'd0, 32'h0BAD, 32'h9090);
    cdb_vld = 2'b10;
    cdb_tag = {4'd2, 4'd0};
    cdb_val = {32'h5A5A, 32'h0};
    exp_q.push_back(mk(4'd9, 32'h5A5A, 32'h9090));
    tick();
    in_vld  = 1'b0;
    cdb_vld = '0;
    tick();
    tests_run++;
    if (iss_vld !== 1'b1 || iss_dest !== 4'd9 || iss_vj !== 32'h5A5A) begin
      tests_failed++; $display("FAIL bypass_vj: got dest %0d vj %h, required 9 00005a5a", iss_dest, iss_vj);
    end
    drain();
  endtask

  task automatic test_full();
    iss_rdy = 1'b1;
    for (int i = 0; i < 8; i++) begin
      disp(4'(i + 1), 4'd5, 4'd0, 32'h100 + 32'(i), 32'h200 + 32'(i));
      tick();
    end
    tests_run++;
    if (count !== 4'd8 || full !== 1'b1) begin
      tests_failed++; $display("FAIL full_fill: got count %0d full %0b, required 8 1", count, full);
    end
    disp(4'd15, 4'd0, 4'd0, 32'hFFFF, 32'hFFFF);
    tick();
    in_vld = 1'b0;
    tests_run++;
    if (count !== 4'd8 || full !== 1'b1 || iss_vld !== 1'b0) begin
      tests_failed++; $display("FAIL full_drop: got count %0d full %0b vld %0b, required 8 1 0", count, full, iss_vld);
    end
    for (int i = 0; i < 8; i++) exp_q.push_back(mk(4'(i + 1), 32'h5555_0005, 32'h200 + 32'(i)));
    cdb_vld = 2'b11;
    cdb_tag = {4'd5, 4'd0};
    cdb_val = {32'h5555_0005, 32'hDEAD_BEEF};
    tick();
    cdb_vld = '0;
    tests_run++;
    if (iss_vld !== 1'b0 || count !== 4'd8) begin
      tests_failed++; $display("FAIL full_wake_delay: got vld %0b count %0d, required 0 8", iss_vld, count);
    end
    tick();
    tests_run++;
    if (iss_vld !== 1'b1 || iss_dest !== 4'd1 || full !== 1'b0 || count !== 4'd7) begin
      tests_failed++;
      $display("FAIL full_first_issue: got dest %0d full %0b count %0d, required 1 0 7", iss_dest, full, count);
    end
    drain();
  endtask

  task automatic test_rdy_freeze();
    iss_rdy = 1'b1;
    disp(4'd10, 4'd6, 4'd0, 32'h0, 32'hA0);
    tick();
    rdy = 1'b0;
    disp(4'd11, 4'd0, 4'd0, 32'h11, 32'h11);
    cdb_vld = 2'b01;
    cdb_tag = {4'd0, 4'd6};
    cdb_val = {32'h0, 32'h0BAD};
    for (int k = 0; k < 3; k++) begin
      tick();
      tests_run++;
      if (count !== 4'd1 || iss_vld !== 1'b0) begin
        tests_failed++; $display("FAIL freeze[%0d]: got count %0d vld %0b, required 1 0", k, count, iss_vld);
      end
    end
    rdy     = 1'b1;
    in_vld  = 1'b0;
    cdb_vld = '0;
    tick();
    tick();
    tests_run++;
    if (count !== 4'd1 || iss_vld !== 1'b0) begin
      tests_failed++; $display("FAIL freeze_after: got count %0d vld %0b, required 1 0", count, iss_vld);
    end
    exp_q.push_back(mk(4'd10, 32'h6666, 32'hA0));
    cdb_vld = 2'b01;
    cdb_val = {32'h0, 32'h6666};
    tick();
    drain();
  endtask

  task automatic test_flush();
    mon_en  = 1'b0;
    iss_rdy = 1'b0;
    disp(4'd1, 4'd0, 4'd0, 32'h1, 32'h1);
    tick();
    disp(4'd2, 4'd4, 4'd0, 32'h2, 32'h2);
    tick();
    disp(4'd3, 4'd0, 4'd0, 32'h3, 32'h3);
    tick();
    flush   = 1'b1;
    disp(4'd4, 4'd0, 4'd0, 32'h4, 32'h4);
    cdb_vld = 2'b01;
    cdb_tag = {4'd0, 4'd4};
    cdb_val = {32'h0, 32'h4444};
    iss_rdy = 1'b1;
    tick();
    flush   = 1'b0;
    in_vld  = 1'b0;
    cdb_vld = '0;
    tests_run++;
    if (count !== 4'd0 || iss_vld !== 1'b0 || full !== 1'b0) begin
      tests_failed++; $display("FAIL flush: got count %0d vld %0b full %0b, required 0 0 0", count, iss_vld, full);
    end
    tick();
    tick();
    tests_run++;
    if (count !== 4'd0 || iss_vld !== 1'b0) begin
      tests_failed++; $display("FAIL flush_stays: got count %0d vld %0b, required 0 0", count, iss_vld);
    end
    mon_en = 1'b1;
  endtask

  task automatic test_random_stream();
    logic [31:0] v;
    for (int i = 0; i < 300; i++) begin
      iss_rdy = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 3) != 0) begin
        v = $urandom;
        disp(4'(i), 4'd0, 4'd0, v, ~v);
        if (!full) exp_q.push_back(mk(4'(i), v, ~v));
      end else begin
        in_vld = 1'b0;
      end
      tick();
    end
    drain();
  endtask

  task automatic test_reset_mid();
    mon_en  = 1'b0;
    iss_rdy = 1'b0;
    disp(4'd1, 4'd0, 4'd0, 32'h77, 32'h88);
    tick();
    disp(4'd2, 4'd9, 4'd0, 32'h99, 32'hAA);
    tick();
    rst = 1'b0;
    rdy = 1'b0;
    disp(4'd3, 4'd0, 4'd0, 32'h33, 32'h33);
    tick();
    rst    = 1'b1;
    rdy    = 1'b1;
    in_vld = 1'b0;
    tests_run++;
    if (iss_vld !== 1'b0 || count !== 4'd0 || full !== 1'b0) begin
      tests_failed++; $display("FAIL rst_mid_ctrl: got vld %0b count %0d full %0b, required 0 0 0", iss_vld, count, full);
    end
    tests_run++;
    if ({iss_vj, iss_vk, iss_imm, iss_pc, iss_op, iss_dest} !== '0) begin
      tests_failed++; $display("FAIL rst_mid_data: got vj %h dest %0d, required 0 0", iss_vj, iss_dest);
    end
    tick();
    tests_run++;
    if (iss_vld !== 1'b0 || count !== 4'd0) begin
      tests_failed++; $display("FAIL rst_mid_after: got vld %0b count %0d, required 0 0", iss_vld, count);
    end
    exp_q.delete();
    mon_en = 1'b1;
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_wakeup_order();
    test_hold_age();
    test_bypass();
    test_full();
    test_rdy_freeze();
    test_flush();
    test_random_stream();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/rs_age.md
RS_AGE -- requirements
Module: rs_age

Interface
REQ-001 SHALL have parameter DEPTH, default 8, meaning number of entries (power of two, 2..32).
REQ-002 SHALL have parameter TAG_W, default 4, meaning ROB tag width; tag 0 means "value ready".
REQ-003 SHALL have parameter NCDB, default 2, meaning number of result broadcast ports.
REQ-004 SHALL have parameter OP_W, default 4, meaning opcode width.
REQ-005 SHALL have port clk  in  1  system clock; the block uses one clock, all state on rising edge.
REQ-006 SHALL have port rst  in  1  reset, synchronous, active-low.
REQ-007 SHALL have port rdy  in  1  global ready; low freezes all state and ignores all inputs.
REQ-008 SHALL have port flush  in  1  branch-mispredict clear.
REQ-009 SHALL have ports in_vld/in_vj/in_qj/in_vk/in_qk/in_op/in_dest/in_pc/in_imm  in  1/32/TAG_W/32/TAG_W/OP_W/TAG_W/32/32  dispatch request and fields.
REQ-010 SHALL have port cdb_vld  in  NCDB  per-port broadcast valid.
REQ-011 SHALL have port cdb_tag  in  NCDB*TAG_W  flattened tags, port k at bits [k*TAG_W +: TAG_W].
REQ-012 SHALL have port cdb_val  in  NCDB*32  flattened values, port k at [k*32 +: 32].
REQ-013 SHALL have port full  out  1  no free entry (combinational from registered state).
REQ-014 SHALL have port count  out  $clog2(DEPTH)+1  occupied entries (registered).
REQ-015 SHALL have ports iss_vld  out  1, iss_rdy  in  1  issue handshake to ALU.
REQ-016 SHALL have ports iss_vj/iss_vk/iss_imm/iss_pc/iss_op/iss_dest  out  32/32/32/32/OP_W/TAG_W  issued operation (registered).

Function
REQ-017 SHALL accept a dispatch when rdy && in_vld && !full && !flush; in_vld while full SHALL be dropped with no state change.
REQ-018 SHALL write an accepted dispatch into the lowest-index free entry as seen before the edge; a slot freed in the same cycle is not reusable until the next cycle.
REQ-019 SHALL bypass on insert: if a valid CDB port with nonzero tag equals in_qj (in_qk), the entry stores Q=0 and that port's value instead of in_vj (in_vk).
REQ-020 SHALL wake up every busy entry whose Qj/Qk equals a valid nonzero cdb_tag, setting Q=0 and V=cdb_val.
REQ-021 SHALL resolve several ports matching the same tag by taking the lowest port index.
REQ-022 SHALL ignore CDB ports whose tag is 0.
REQ-023 SHALL treat an entry as ready when busy and Qj==0 and Qk==0 in registered state; wake-up makes it eligible the cycle after the broadcast.
REQ-024 SHALL select the oldest ready entry (earliest accepted dispatch) for issue, not the lowest index.
REQ-025 SHALL load the output register and free the selected entry when a ready entry exists and (!iss_vld || iss_rdy); iss_vld SHALL then be 1.
REQ-026 SHALL clear iss_vld when iss_rdy is high and no ready entry exists.
REQ-027 SHALL hold all iss_* outputs stable while iss_vld && !iss_rdy.
REQ-028 SHALL give minimum latency 1: dispatch with both Q=0 accepted at edge N -> iss_vld high after edge N+1.
REQ-029 SHALL update count by +accept -issue-load each edge; simultaneous accept and issue-load leaves count unchanged.
REQ-030 SHALL on flush (with rdy high) clear all busy bits, count, iss_vld and age state, and drop the same-cycle dispatch; flush SHALL have priority over dispatch, wake-up and issue.
REQ-031 SHALL preserve relative age across wrap-around of any internal sequence counter, for arbitrarily long runs.

Reset
REQ-032 SHALL on rst low at an edge clear all busy bits, count=0, iss_vld=0 and age state; iss data outputs SHALL reset to 0.
REQ-033 SHALL give reset priority over rdy, flush and all other inputs.
REQ-034 SHALL have full=1 only when count==DEPTH; full=0 immediately after reset.

Verification
REQ-035 SHALL be verified by this case: insert A(qj=3) then B (both ready), then broadcast tag 3 -> B issues first; A issues one cycle after wake-up, not the same cycle.
REQ-036 SHALL be verified by this case: fill 8 entries with qj=5, then in_vld while full -> count stays 8 and nothing is written; then broadcast tag 5 on port 1 -> issue in insertion order.
REQ-037 SHALL be verified by this case: dispatch in_qk=7 in the same cycle cdb port0 tag=7 val=0x1234 -> entry stores vk=0x1234 and issues at latency 1.
REQ-038 SHALL be verified by this case: iss_rdy held low 5 cycles with iss_vld=1 -> iss_* unchanged and no entry freed; iss_rdy high -> next oldest loads.
REQ-039 SHALL be verified by this case: flush concurrent with dispatch, issue and broadcast -> next cycle count=0, iss_vld=0, full=0.
REQ-040 SHALL be verified by this case: rdy low for 3 cycles during broadcast and dispatch -> no state change; rst low mid-operation -> all outputs at reset values next cycle.
